// File: rtl/c3aibadapt_txclk_sel_seq.sv
// ----------------------------------------------------------------------------
// c3aibadapt_txclk_sel_seq
//
// Sequences TX clock-control configuration changes into c3aibadapt_txclk_ctl.
// A requested FIFO read-clock select / power-mode change is applied only while
// both FIFO clocks are statically gated and the read domain is held in reset,
// so the downstream select mux never switches a live clock.
//
// Sequence: IDLE -> GATE (GATE_WAIT cycles) -> SETTLE (SETTLE_WAIT cycles)
//           -> RELEASE (1 cycle) -> IDLE.
// After reset the block runs SETTLE -> RELEASE -> IDLE without an ack.
//
// Ports:
//   tx_osc_clk               in   clock for all state
//   tx_osc_rst               in   synchronous active-high reset
//   cfg_req                  in   level request to apply the cfg_* values
//   cfg_rd_clk_sel[1:0]      in   requested read-clock select
//   cfg_fifo_power_mode[1:0] in   requested FIFO power mode
//   r_tx_fifo_rd_clk_sel     out  read-clock select to txclk_ctl
//   r_tx_fifo_rd_clk_scg_en  out  read-clock static gate (1 = gated)
//   r_tx_fifo_wr_clk_scg_en  out  write-clock static gate (1 = gated)
//   r_tx_fifo_power_mode     out  FIFO power mode to txclk_ctl
//   tx_fifo_rd_rst           out  hold reset for the FIFO read domain
//   busy                     out  a sequence is in progress
//   cfg_ack                  out  1-cycle pulse: requested sequence done
//   cfg_err                  out  1-cycle pulse per request seen while busy
//
// All outputs come straight from flops; there is no input-to-output path.
// ----------------------------------------------------------------------------
module c3aibadapt_txclk_sel_seq #(
    parameter int unsigned GATE_WAIT   = 4,     // >= 1
    parameter int unsigned SETTLE_WAIT = 8,     // >= 1
    parameter int unsigned CNT_W       = 4,     // 2**CNT_W >= max waits
    parameter logic [1:0]  RST_SEL     = 2'b11  // transfer div2
) (
    input  logic       tx_osc_clk,
    input  logic       tx_osc_rst,
    input  logic       cfg_req,
    input  logic [1:0] cfg_rd_clk_sel,
    input  logic [1:0] cfg_fifo_power_mode,
    output logic [1:0] r_tx_fifo_rd_clk_sel,
    output logic       r_tx_fifo_rd_clk_scg_en,
    output logic       r_tx_fifo_wr_clk_scg_en,
    output logic [1:0] r_tx_fifo_power_mode,
    output logic       tx_fifo_rd_rst,
    output logic       busy,
    output logic       cfg_ack,
    output logic       cfg_err
);

    localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_WAIT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_WAIT - 1);
    localparam logic [1:0]       RST_PM      = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GATE,
        ST_SETTLE,
        ST_RELEASE
    } state_e;

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [1:0]         sel_q,      sel_d;
    logic [1:0]         pm_q,       pm_d;
    logic [1:0]         hold_sel_q, hold_sel_d;
    logic [1:0]         hold_pm_q,  hold_pm_d;
    logic               rd_scg_q,   rd_scg_d;
    logic               wr_scg_q,   wr_scg_d;
    logic               rd_rst_q,   rd_rst_d;
    logic               busy_q,     busy_d;
    logic               ack_q,      ack_d;
    logic               err_q,      err_d;
    // Distinguishes a requested sequence (acked) from the post-reset init.
    logic               req_seq_q,  req_seq_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        pm_d       = pm_q;
        hold_sel_d = hold_sel_q;
        hold_pm_d  = hold_pm_q;
        rd_scg_d   = rd_scg_q;
        wr_scg_d   = wr_scg_q;
        rd_rst_d   = rd_rst_q;
        busy_d     = busy_q;
        req_seq_d  = req_seq_q;
        ack_d      = 1'b0;
        // busy_q is still 1 in RELEASE, so a request there is rejected too.
        err_d      = cfg_req & busy_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_req) begin
                    hold_sel_d = cfg_rd_clk_sel;
                    hold_pm_d  = cfg_fifo_power_mode;
                    rd_scg_d   = 1'b1;
                    wr_scg_d   = 1'b1;
                    rd_rst_d   = 1'b1;
                    busy_d     = 1'b1;
                    req_seq_d  = 1'b1;
                    cnt_d      = GATE_LOAD;
                    state_d    = ST_GATE;
                end
            end
            ST_GATE: begin
                if (cnt_q == '0) begin
                    // Both gates have been closed for GATE_WAIT cycles here.
                    sel_d   = hold_sel_q;
                    pm_d    = hold_pm_q;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    rd_scg_d = 1'b0;
                    wr_scg_d = 1'b0;
                    state_d  = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                rd_rst_d  = 1'b0;
                busy_d    = 1'b0;
                ack_d     = req_seq_q;
                req_seq_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge tx_osc_clk) begin
        if (tx_osc_rst) begin
            // NOTE: the holding registers are reset as well; they are tiny and
            // a defined value keeps them out of X-propagation debates.
            // NOTE: sequential state is always updated with non-blocking
            // assignments so every flop samples pre-edge values.
            state_q    <= ST_SETTLE;
            cnt_q      <= SETTLE_LOAD;
            sel_q      <= RST_SEL;
            pm_q       <= RST_PM;
            hold_sel_q <= RST_SEL;
            hold_pm_q  <= RST_PM;
            rd_scg_q   <= 1'b1;
            wr_scg_q   <= 1'b1;
            rd_rst_q   <= 1'b1;
            busy_q     <= 1'b1;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            req_seq_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            pm_q       <= pm_d;
            hold_sel_q <= hold_sel_d;
            hold_pm_q  <= hold_pm_d;
            rd_scg_q   <= rd_scg_d;
            wr_scg_q   <= wr_scg_d;
            rd_rst_q   <= rd_rst_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            req_seq_q  <= req_seq_d;
        end
    end

    assign r_tx_fifo_rd_clk_sel    = sel_q;
    assign r_tx_fifo_power_mode    = pm_q;
    assign r_tx_fifo_rd_clk_scg_en = rd_scg_q;
    assign r_tx_fifo_wr_clk_scg_en = wr_scg_q;
    assign tx_fifo_rd_rst          = rd_rst_q;
    assign busy                    = busy_q;
    assign cfg_ack                 = ack_q;
    assign cfg_err                 = err_q;

endmodule

// File: tb/tb_c3aibadapt_txclk_sel_seq.sv
// ----------------------------------------------------------------------------
// Testbench for c3aibadapt_txclk_sel_seq.
// Each scenario task drives stimulus at the falling edge and, for every rising
// edge, pushes the expected output vector (derived from the documented cycle
// timeline) into a scoreboard queue; the queue is drained and compared at the
// following falling edge. A select/power-mode change with an open gate is
// flagged separately.
// ----------------------------------------------------------------------------
module tb_c3aibadapt_txclk_sel_seq;

    localparam int         G       = 4;
    localparam int         S       = 8;
    localparam logic [1:0] RST_SEL = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_req;
    logic [1:0] cfg_rd_clk_sel;
    logic [1:0] cfg_fifo_power_mode;
    logic [1:0] r_sel;
    logic       r_rscg;
    logic       r_wscg;
    logic [1:0] r_pm;
    logic       rd_rst;
    logic       busy;
    logic       cfg_ack;
    logic       cfg_err;

    always #5 clk = ~clk;

    c3aibadapt_txclk_sel_seq #(
        .GATE_WAIT  (G),
        .SETTLE_WAIT(S),
        .CNT_W      (4),
        .RST_SEL    (RST_SEL)
    ) dut (
        .tx_osc_clk             (clk),
        .tx_osc_rst             (rst),
        .cfg_req                (cfg_req),
        .cfg_rd_clk_sel         (cfg_rd_clk_sel),
        .cfg_fifo_power_mode    (cfg_fifo_power_mode),
        .r_tx_fifo_rd_clk_sel   (r_sel),
        .r_tx_fifo_rd_clk_scg_en(r_rscg),
        .r_tx_fifo_wr_clk_scg_en(r_wscg),
        .r_tx_fifo_power_mode   (r_pm),
        .tx_fifo_rd_rst         (rd_rst),
        .busy                   (busy),
        .cfg_ack                (cfg_ack),
        .cfg_err                (cfg_err)
    );

    // Vector layout: {sel[1:0], pm[1:0], rd_scg, wr_scg, rd_rst, busy, ack, err}
    typedef struct {
        string      tag;
        logic [9:0] v;
    } exp_t;

    exp_t       exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         ack_seen    = 0;
    int         err_seen    = 0;
    logic [1:0] cur_sel;
    logic [1:0] cur_pm;
    logic [1:0] prev_sel;
    logic [1:0] prev_pm;
    bit         prev_valid  = 1'b0;

    function automatic exp_t mk(input string tag, input logic [1:0] sel,
                                input logic [1:0] pm, input logic gate,
                                input logic rrst, input logic bsy,
                                input logic ack, input logic err);
        exp_t e;
        e.tag = tag;
        e.v   = {sel, pm, gate, gate, rrst, bsy, ack, err};
        return e;
    endfunction

    // One clock: push the expectation for this rising edge, then drain the
    // scoreboard against the DUT at the falling edge.
    task automatic clock_cycle(input exp_t e);
        exp_t       x;
        logic [9:0] obs;
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
        obs = {r_sel, r_pm, r_rscg, r_wscg, rd_rst, busy, cfg_ack, cfg_err};
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            vectors++;
            if (obs !== x.v) begin
                miscompares++;
                $display("FAIL %s @%0t: got sel/pm/rg/wg/rrst/busy/ack/err=%b required %b",
                         x.tag, $time, obs, x.v);
            end
        end
        if (prev_valid && (r_sel !== prev_sel || r_pm !== prev_pm)) begin
            vectors++;
            if (r_rscg !== 1'b1 || r_wscg !== 1'b1) begin
                miscompares++;
                $display("FAIL sel_change_ungated @%0t: gates rd=%b wr=%b required 1/1",
                         $time, r_rscg, r_wscg);
            end
        end
        prev_sel   = r_sel;
        prev_pm    = r_pm;
        prev_valid = 1'b1;
        if (cfg_ack === 1'b1) ack_seen++;
        if (cfg_err === 1'b1) err_seen++;
    endtask

    // Post-reset init: gates open at r+S-1, busy drops at r+S, no ack.
    task automatic init_seq(input string tag);
        cur_sel = RST_SEL;
        cur_pm  = 2'b11;
        for (int j = 0; j <= S + 1; j++)
            clock_cycle(mk(tag, cur_sel, cur_pm, j < S - 1, j < S, j < S, 1'b0, 1'b0));
    endtask

    // Request accepted at edge k (j = 0). cfg_req held for 'hold' edges; the
    // inputs switch to alt values after edge k. abort_at > 0 asserts reset so
    // that it is sampled at edge k+abort_at.
    task automatic run_req(input string tag, input logic [1:0] sel,
                           input logic [1:0] pm, input int hold,
                           input logic [1:0] alt_sel, input int abort_at);
        logic [1:0] old_sel = cur_sel;
        logic [1:0] old_pm  = cur_pm;
        cfg_rd_clk_sel      = sel;
        cfg_fifo_power_mode = pm;
        cfg_req             = 1'b1;
        for (int j = 0; j <= G + S + 1; j++) begin
            if (abort_at > 0 && j == abort_at) begin
                rst     = 1'b1;
                cfg_req = 1'b0;
                clock_cycle(mk({tag, "_rst"}, RST_SEL, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
                rst = 1'b0;
                init_seq({tag, "_init"});
                return;
            end
            clock_cycle(mk(tag,
                           (j >= G) ? sel : old_sel,
                           (j >= G) ? pm  : old_pm,
                           j <= G + S - 1,
                           j <= G + S,
                           j <= G + S,
                           j == G + S + 1,
                           (j >= 1) && (j <= hold - 1)));
            if (j + 1 >= hold) cfg_req = 1'b0;
            if (j == 0) begin
                cfg_rd_clk_sel      = alt_sel;
                cfg_fifo_power_mode = ~pm;
            end
        end
        cur_sel = sel;
        cur_pm  = pm;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) clock_cycle(mk("idle", cur_sel, cur_pm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic test_reset();
        int a0 = ack_seen;
        rst     = 1'b1;
        cfg_req = 1'b0;
        cfg_rd_clk_sel      = 2'b00;
        cfg_fifo_power_mode = 2'b00;
        repeat (3) clock_cycle(mk("reset", RST_SEL, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        rst = 1'b0;
        init_seq("init");
        vectors++;
        if (ack_seen - a0 !== 0) begin
            miscompares++;
            $display("FAIL init_ack_count: got %0d required 0", ack_seen - a0);
        end
    endtask

    task automatic test_basic_switch();
        int a0 = ack_seen;
        int e0 = err_seen;
        run_req("basic", 2'b01, 2'b00, 1, 2'b01, 0);
        idle_cycles(2);
        vectors++;
        if (ack_seen - a0 !== 1 || err_seen - e0 !== 0) begin
            miscompares++;
            $display("FAIL basic_ack_err: got ack=%0d err=%0d required ack=1 err=0",
                     ack_seen - a0, err_seen - e0);
        end
    endtask

    task automatic test_busy_collision();
        int a0 = ack_seen;
        int e0 = err_seen;
        run_req("collide", 2'b00, 2'b01, 3, 2'b10, 0);
        idle_cycles(2);
        vectors++;
        if (ack_seen - a0 !== 1 || err_seen - e0 !== 2) begin
            miscompares++;
            $display("FAIL collide_ack_err: got ack=%0d err=%0d required ack=1 err=2",
                     ack_seen - a0, err_seen - e0);
        end
    endtask

    task automatic test_back_to_back();
        int a0 = ack_seen;
        int e0 = err_seen;
        run_req("b2b_first", 2'b10, 2'b10, 1, 2'b10, 0);
        run_req("b2b_second", 2'b01, 2'b11, 1, 2'b01, 0);
        idle_cycles(1);
        vectors++;
        if (ack_seen - a0 !== 2 || err_seen - e0 !== 0) begin
            miscompares++;
            $display("FAIL b2b_ack_err: got ack=%0d err=%0d required ack=2 err=0",
                     ack_seen - a0, err_seen - e0);
        end
    endtask

    task automatic test_mid_reset();
        int a0 = ack_seen;
        run_req("midrst", 2'b00, 2'b01, 1, 2'b00, 6);
        idle_cycles(1);
        vectors++;
        if (ack_seen - a0 !== 0) begin
            miscompares++;
            $display("FAIL midrst_ack_count: got %0d required 0", ack_seen - a0);
        end
    endtask

    task automatic test_same_value();
        int a0 = ack_seen;
        run_req("same", cur_sel, cur_pm, 1, cur_sel, 0);
        idle_cycles(1);
        vectors++;
        if (ack_seen - a0 !== 1) begin
            miscompares++;
            $display("FAIL same_ack_count: got %0d required 1", ack_seen - a0);
        end
    endtask

    initial begin
        test_reset();
        idle_cycles(1);
        test_basic_switch();
        test_busy_collision();
        test_back_to_back();
        test_mid_reset();
        test_same_value();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
